// File: rtl/blob_stats_accum.sv
// Second-pass CCL statistics: per-label bounding box and area, equivalence merge, blob record emission.
// Optional feature: define BLOB_STATS_CENTROID_EN to accumulate and emit per-blob coordinate sums.
module blob_stats_accum #(
    parameter int COLW      = 14,
    parameter int ROWW      = 12,
    parameter int LABELSIZE = 8,
    parameter int CNTW      = 20
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 frame_valid,
    input  logic                 data_valid,
    input  logic [LABELSIZE-1:0] label_in,
    input  logic [COLW-1:0]      col_cnt,
    output logic [LABELSIZE:0]   ll_index,
    input  logic [LABELSIZE-1:0] ll_data,
    output logic                 blob_valid,
    input  logic                 blob_ready,
    output logic [LABELSIZE-1:0] blob_label,
    output logic [COLW-1:0]      blob_xmin,
    output logic [COLW-1:0]      blob_xmax,
    output logic [ROWW-1:0]      blob_ymin,
    output logic [ROWW-1:0]      blob_ymax,
    output logic [CNTW-1:0]      blob_area,
    output logic [COLW+CNTW-1:0] blob_sumx,
    output logic [ROWW+CNTW-1:0] blob_sumy,
    output logic                 blob_last,
    output logic                 frame_done,
    output logic                 frame_dropped,
    output logic                 busy
);

    localparam int NL  = 1 << LABELSIZE;
    localparam int SXW = COLW + CNTW;
    localparam int SYW = ROWW + CNTW;

    typedef enum logic [1:0] {IDLE, ACCUM, MERGE, EMIT} state_t;

    state_t               state_q, state_d;
    logic                 frame_valid_q;
    logic [COLW-1:0]      x_q, x_d;
    logic [ROWW-1:0]      y_q, y_d;
    logic [LABELSIZE-1:0] max_label_q, max_label_d;
    logic [LABELSIZE-1:0] l_q, l_d;
    logic [LABELSIZE-1:0] p_q, p_d;
    logic                 phase_q, phase_d;
    logic                 pend_q, pend_d;
    logic [LABELSIZE-1:0] pend_label_q, pend_label_d;
    logic [COLW-1:0]      pend_x_q, pend_x_d;
    logic [ROWW-1:0]      pend_y_q, pend_y_d;
    logic                 frame_done_q, frame_done_d;
    logic                 frame_dropped_q, frame_dropped_d;
    logic [NL-1:0]        valid_q, valid_d;
    logic [LABELSIZE-1:0] top_label;
    logic                 rise, accept, emit_adv;

    logic [COLW-1:0]      xmin_q [NL];
    logic [COLW-1:0]      xmax_q [NL];
    logic [ROWW-1:0]      ymin_q [NL];
    logic [ROWW-1:0]      ymax_q [NL];
    logic [CNTW-1:0]      area_q [NL];

    logic                 wr_en;
    logic [LABELSIZE-1:0] wr_idx;
    logic [COLW-1:0]      wr_xmin, wr_xmax;
    logic [ROWW-1:0]      wr_ymin, wr_ymax;
    logic [CNTW-1:0]      wr_area;

`ifdef BLOB_STATS_CENTROID_EN
    logic [SXW-1:0]       sumx_q [NL];
    logic [SYW-1:0]       sumy_q [NL];
    logic [SXW-1:0]       wr_sumx;
    logic [SYW-1:0]       wr_sumy;
`endif

    function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] a, input logic [CNTW-1:0] b);
        logic [CNTW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNTW] ? {CNTW{1'b1}} : s[CNTW-1:0];
    endfunction

    assign rise     = frame_valid & ~frame_valid_q;
    assign accept   = frame_valid & data_valid & ((state_q == ACCUM) | ((state_q == IDLE) & rise));
    assign emit_adv = (state_q == EMIT) & (~valid_q[l_q] | blob_ready);

    // Pixel capture stage: coordinates advance on every accepted pixel, background never enters the table.
    always_comb begin
        pend_d       = accept & (label_in != '0);
        pend_label_d = label_in;
        pend_x_d     = x_q;
        pend_y_d     = y_q;
        x_d          = x_q;
        y_d          = y_q;
        if (accept) begin
            if (x_q == col_cnt - 1'b1) begin
                x_d = '0;
                y_d = y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
        if (state_q == ACCUM && !frame_valid) begin
            x_d = '0;
            y_d = '0;
        end
    end

    always_comb begin
        state_d         = state_q;
        max_label_d     = max_label_q;
        l_d             = l_q;
        p_d             = p_q;
        phase_d         = phase_q;
        valid_d         = valid_q;
        frame_done_d    = 1'b0;
        frame_dropped_d = frame_dropped_q;
        wr_en           = 1'b0;
        wr_idx          = pend_label_q;
        wr_xmin         = pend_x_q;
        wr_xmax         = pend_x_q;
        wr_ymin         = pend_y_q;
        wr_ymax         = pend_y_q;
        wr_area         = CNTW'(1);
`ifdef BLOB_STATS_CENTROID_EN
        wr_sumx         = SXW'(pend_x_q);
        wr_sumy         = SYW'(pend_y_q);
`endif
        // The commit reads the table after the previous commit's write, so same-label runs never lose a count.
        if (pend_q) begin
            wr_en = 1'b1;
            valid_d[pend_label_q] = 1'b1;
            if (valid_q[pend_label_q]) begin
                wr_xmin = (pend_x_q < xmin_q[pend_label_q]) ? pend_x_q : xmin_q[pend_label_q];
                wr_xmax = (pend_x_q > xmax_q[pend_label_q]) ? pend_x_q : xmax_q[pend_label_q];
                wr_ymin = (pend_y_q < ymin_q[pend_label_q]) ? pend_y_q : ymin_q[pend_label_q];
                wr_ymax = (pend_y_q > ymax_q[pend_label_q]) ? pend_y_q : ymax_q[pend_label_q];
                wr_area = sat_add(area_q[pend_label_q], CNTW'(1));
`ifdef BLOB_STATS_CENTROID_EN
                wr_sumx = sumx_q[pend_label_q] + SXW'(pend_x_q);
                wr_sumy = sumy_q[pend_label_q] + SYW'(pend_y_q);
`endif
            end
            if (pend_label_q > max_label_q) begin
                max_label_d = pend_label_q;
            end
        end

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d     = ACCUM;
                    valid_d     = '0;
                    max_label_d = '0;
                end
            end
            ACCUM: begin
                if (!frame_valid) begin
                    l_d     = max_label_d;
                    phase_d = 1'b0;
                    if (max_label_d == '0) begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = MERGE;
                    end
                end
            end
            MERGE: begin
                if (!phase_q) begin
                    p_d     = ll_data;
                    phase_d = 1'b1;
                end else begin
                    if (valid_q[l_q] && p_q != '0 && p_q < l_q) begin
                        wr_en          = 1'b1;
                        wr_idx         = p_q;
                        valid_d[p_q]   = 1'b1;
                        valid_d[l_q]   = 1'b0;
                        wr_xmin        = xmin_q[l_q];
                        wr_xmax        = xmax_q[l_q];
                        wr_ymin        = ymin_q[l_q];
                        wr_ymax        = ymax_q[l_q];
                        wr_area        = area_q[l_q];
`ifdef BLOB_STATS_CENTROID_EN
                        wr_sumx        = sumx_q[l_q];
                        wr_sumy        = sumy_q[l_q];
`endif
                        if (valid_q[p_q]) begin
                            wr_xmin = (xmin_q[p_q] < xmin_q[l_q]) ? xmin_q[p_q] : xmin_q[l_q];
                            wr_xmax = (xmax_q[p_q] > xmax_q[l_q]) ? xmax_q[p_q] : xmax_q[l_q];
                            wr_ymin = (ymin_q[p_q] < ymin_q[l_q]) ? ymin_q[p_q] : ymin_q[l_q];
                            wr_ymax = (ymax_q[p_q] > ymax_q[l_q]) ? ymax_q[p_q] : ymax_q[l_q];
                            wr_area = sat_add(area_q[p_q], area_q[l_q]);
`ifdef BLOB_STATS_CENTROID_EN
                            wr_sumx = sumx_q[p_q] + sumx_q[l_q];
                            wr_sumy = sumy_q[p_q] + sumy_q[l_q];
`endif
                        end
                    end
                    phase_d = 1'b0;
                    if (l_q == LABELSIZE'(1)) begin
                        state_d = EMIT;
                        l_d     = LABELSIZE'(1);
                    end else begin
                        l_d = l_q - 1'b1;
                    end
                end
            end
            EMIT: begin
                if (emit_adv) begin
                    if (l_q == max_label_q) begin
                        state_d      = IDLE;
                        l_d          = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        l_d = l_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (rise && (state_q == MERGE || state_q == EMIT)) begin
            frame_dropped_d = 1'b1;
        end
    end

    // Highest surviving label marks the last record of the frame.
    always_comb begin
        top_label = '0;
        for (int i = 0; i < NL; i++) begin
            if (valid_q[i]) begin
                top_label = LABELSIZE'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            frame_valid_q   <= 1'b0;
            x_q             <= '0;
            y_q             <= '0;
            max_label_q     <= '0;
            l_q             <= '0;
            p_q             <= '0;
            phase_q         <= 1'b0;
            pend_q          <= 1'b0;
            pend_label_q    <= '0;
            pend_x_q        <= '0;
            pend_y_q        <= '0;
            frame_done_q    <= 1'b0;
            frame_dropped_q <= 1'b0;
            valid_q         <= '0;
        end else begin
            state_q         <= state_d;
            frame_valid_q   <= frame_valid;
            x_q             <= x_d;
            y_q             <= y_d;
            max_label_q     <= max_label_d;
            l_q             <= l_d;
            p_q             <= p_d;
            phase_q         <= phase_d;
            pend_q          <= pend_d;
            pend_label_q    <= pend_label_d;
            pend_x_q        <= pend_x_d;
            pend_y_q        <= pend_y_d;
            frame_done_q    <= frame_done_d;
            frame_dropped_q <= frame_dropped_d;
            valid_q         <= valid_d;
        end
    end

    // Table contents need no reset; entry-valid bits gate every use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            xmin_q[wr_idx] <= wr_xmin;
            xmax_q[wr_idx] <= wr_xmax;
            ymin_q[wr_idx] <= wr_ymin;
            ymax_q[wr_idx] <= wr_ymax;
            area_q[wr_idx] <= wr_area;
`ifdef BLOB_STATS_CENTROID_EN
            sumx_q[wr_idx] <= wr_sumx;
            sumy_q[wr_idx] <= wr_sumy;
`endif
        end
    end

    assign ll_index      = {1'b0, l_q};
    assign blob_valid    = (state_q == EMIT) & valid_q[l_q];
    assign blob_label    = blob_valid ? l_q : '0;
    assign blob_xmin     = blob_valid ? xmin_q[l_q] : '0;
    assign blob_xmax     = blob_valid ? xmax_q[l_q] : '0;
    assign blob_ymin     = blob_valid ? ymin_q[l_q] : '0;
    assign blob_ymax     = blob_valid ? ymax_q[l_q] : '0;
    assign blob_area     = blob_valid ? area_q[l_q] : '0;
    assign blob_last     = blob_valid & (l_q == top_label);
    assign frame_done    = frame_done_q;
    assign frame_dropped = frame_dropped_q;
    assign busy          = (state_q == MERGE) | (state_q == EMIT);
`ifdef BLOB_STATS_CENTROID_EN
    assign blob_sumx     = blob_valid ? sumx_q[l_q] : '0;
    assign blob_sumy     = blob_valid ? sumy_q[l_q] : '0;
`else
    assign blob_sumx     = '0;
    assign blob_sumy     = '0;
`endif

endmodule

// File: tb/tb_blob_stats_accum.sv
// Self-checking bench for blob_stats_accum: directed scenarios plus randomized frames against a label-map model.
// Coordinate sums are expected only when BLOB_STATS_CENTROID_EN is defined.
module tb_blob_stats_accum;

    localparam int COLW = 14;
    localparam int ROWW = 12;
    localparam int LABELSIZE = 8;
    localparam int CNTW = 20;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 frame_valid;
    logic                 data_valid;
    logic [LABELSIZE-1:0] label_in;
    logic [COLW-1:0]      col_cnt;
    logic [LABELSIZE:0]   ll_index;
    logic [LABELSIZE-1:0] ll_data;
    logic                 blob_valid;
    logic                 blob_ready;
    logic [LABELSIZE-1:0] blob_label;
    logic [COLW-1:0]      blob_xmin, blob_xmax;
    logic [ROWW-1:0]      blob_ymin, blob_ymax;
    logic [CNTW-1:0]      blob_area;
    logic [COLW+CNTW-1:0] blob_sumx;
    logic [ROWW+CNTW-1:0] blob_sumy;
    logic                 blob_last, frame_done, frame_dropped, busy;

    blob_stats_accum dut (
        .clk(clk), .reset_n(reset_n), .frame_valid(frame_valid), .data_valid(data_valid),
        .label_in(label_in), .col_cnt(col_cnt), .ll_index(ll_index), .ll_data(ll_data),
        .blob_valid(blob_valid), .blob_ready(blob_ready), .blob_label(blob_label),
        .blob_xmin(blob_xmin), .blob_xmax(blob_xmax), .blob_ymin(blob_ymin), .blob_ymax(blob_ymax),
        .blob_area(blob_area), .blob_sumx(blob_sumx), .blob_sumy(blob_sumy), .blob_last(blob_last),
        .frame_done(frame_done), .frame_dropped(frame_dropped), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [7:0] ll_map [256];
    assign ll_data = ll_map[ll_index[7:0]];

    typedef struct packed {
        logic [7:0]  label;
        logic [13:0] xmin;
        logic [13:0] xmax;
        logic [11:0] ymin;
        logic [11:0] ymax;
        logic [19:0] area;
        logic [33:0] sumx;
        logic [31:0] sumy;
        logic        last;
    } rec_t;

    rec_t       got_q[$];
    rec_t       exp_q[$];
    logic [7:0] pix[$];
    int         fw, fh;
    int         checks = 0;
    int         failures = 0;

    function automatic rec_t cur_rec();
        rec_t r;
        r.label = blob_label; r.xmin = blob_xmin; r.xmax = blob_xmax;
        r.ymin = blob_ymin; r.ymax = blob_ymax; r.area = blob_area;
        r.sumx = blob_sumx; r.sumy = blob_sumy; r.last = blob_last;
        return r;
    endfunction

    function automatic rec_t exp_rec(input int lab, input int x0, input int x1, input int y0, input int y1,
                                     input int area, input longint sx, input longint sy, input int last);
        rec_t r;
        r = '0;
        r.label = 8'(lab); r.xmin = 14'(x0); r.xmax = 14'(x1);
        r.ymin = 12'(y0); r.ymax = 12'(y1); r.area = 20'(area); r.last = (last != 0);
`ifdef BLOB_STATS_CENTROID_EN
        r.sumx = 34'(sx); r.sumy = 32'(sy);
`else
        r.sumx = 34'(sx & 0); r.sumy = 32'(sy & 0);
`endif
        return r;
    endfunction

    task automatic set_identity();
        for (int i = 0; i < 256; i++) ll_map[i] = 8'(i);
    endtask

    task automatic blank_frame(input int w, input int h);
        fw = w; fh = h;
        pix.delete();
        for (int i = 0; i < w * h; i++) pix.push_back(8'd0);
    endtask

    // Behavioural reference: each labelled pixel is credited to the root reached by following the
    // equivalence map downward; surviving roots are reported in ascending order.
    task automatic model_frame();
        bit     v[256];
        int     xmn[256], xmx[256], ymn[256], ymx[256], ar[256];
        longint sx[256], sy[256];
        int     r, x, y;
        rec_t   e;
        exp_q.delete();
        for (int i = 0; i < 256; i++) v[i] = 0;
        for (int i = 0; i < pix.size(); i++) begin
            if (pix[i] == 0) continue;
            x = i % fw; y = i / fw; r = int'(pix[i]);
            while (ll_map[r] != 0 && int'(ll_map[r]) < r) r = int'(ll_map[r]);
            if (!v[r]) begin
                v[r] = 1; xmn[r] = x; xmx[r] = x; ymn[r] = y; ymx[r] = y; ar[r] = 0; sx[r] = 0; sy[r] = 0;
            end
            if (x < xmn[r]) xmn[r] = x;
            if (x > xmx[r]) xmx[r] = x;
            if (y < ymn[r]) ymn[r] = y;
            if (y > ymx[r]) ymx[r] = y;
            if (ar[r] < (1 << CNTW) - 1) ar[r]++;
            sx[r] += x; sy[r] += y;
        end
        for (int l = 1; l < 256; l++) begin
            if (v[l]) exp_q.push_back(exp_rec(l, xmn[l], xmx[l], ymn[l], ymx[l], ar[l], sx[l], sy[l], 0));
        end
        if (exp_q.size() > 0) begin
            e = exp_q[exp_q.size() - 1];
            e.last = 1'b1;
            exp_q[exp_q.size() - 1] = e;
        end
    endtask

    // One stray data_valid in IDLE (must be ignored), one quiet cycle with frame_valid high, then the pixels.
    task automatic drive_frame(input int gap);
        @(negedge clk);
        col_cnt = COLW'(fw); frame_valid = 1'b0; data_valid = 1'b1; label_in = 8'($urandom_range(1, 255));
        @(negedge clk);
        frame_valid = 1'b1; data_valid = 1'b0;
        for (int i = 0; i < pix.size(); i++) begin
            while (gap > 0 && int'($urandom_range(0, 99)) < gap) begin
                @(negedge clk);
                data_valid = 1'b0; label_in = 8'($urandom);
            end
            @(negedge clk);
            data_valid = 1'b1; label_in = pix[i];
        end
        @(negedge clk);
        frame_valid = 1'b0; data_valid = 1'b0; label_in = '0;
    endtask

    // Records every transfer until frame_done, then watches a few more cycles.
    task automatic collect(input int ready_pct, output int done_cnt, output int valid_cycles, output bit timeout);
        int cyc, tail;
        got_q.delete();
        done_cnt = 0; valid_cycles = 0; timeout = 0; cyc = 0; tail = -1;
        while (tail != 0) begin
            @(negedge clk);
            blob_ready = (int'($urandom_range(0, 99)) < ready_pct);
            #1;
            if (blob_valid) valid_cycles++;
            if (blob_valid && blob_ready) got_q.push_back(cur_rec());
            if (frame_done) begin
                done_cnt++;
                if (tail < 0) tail = 4;
            end
            if (tail > 0) tail--;
            cyc++;
            if (cyc > 5000 && tail < 0) begin
                timeout = 1;
                break;
            end
        end
        blob_ready = 1'b0;
    endtask

    task automatic wait_valid(output bit found);
        found = 0;
        for (int c = 0; c < 3000 && !found; c++) begin
            @(negedge clk); #1;
            found = blob_valid;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; frame_valid = 1'b0; data_valid = 1'b0; label_in = '0; blob_ready = 1'b0; col_cnt = 14'd8;
        set_identity();
        repeat (3) @(negedge clk);
        checks++;
        if ({blob_valid, blob_last, frame_done, frame_dropped, busy} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags got=%b exp=00000", {blob_valid, blob_last, frame_done, frame_dropped, busy});
        end
        checks++;
        if (ll_index !== 9'd0) begin
            failures++;
            $display("[TB] FAIL reset_ll_index got=%0d exp=0", ll_index);
        end
        checks++;
        if ({blob_label, blob_area, blob_xmax, blob_ymax, blob_sumx} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_fields got=%h exp=0", {blob_label, blob_area, blob_xmax, blob_ymax, blob_sumx});
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_idle_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_single_block();
        int dc, vc; bit to; rec_t e;
        set_identity();
        blank_frame(8, 5);
        for (int y = 1; y <= 3; y++) for (int x = 2; x <= 4; x++) pix[y * 8 + x] = 8'd5;
        drive_frame(0);
        collect(100, dc, vc, to);
        e = exp_rec(5, 2, 4, 1, 3, 9, 27, 18, 1);
        checks++;
        if (to || dc !== 1) begin
            failures++;
            $display("[TB] FAIL block_done got=%0d timeout=%0b exp=1", dc, to);
        end
        checks++;
        if (got_q.size() !== 1) begin
            failures++;
            $display("[TB] FAIL block_count got=%0d exp=1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== e) begin
                failures++;
                $display("[TB] FAIL block_record got=%h exp=%h", got_q[0], e);
            end
        end
    endtask

    task automatic test_u_merge();
        int dc, vc; bit to; rec_t e;
        set_identity();
        ll_map[2] = 8'd1;
        blank_frame(8, 4);
        for (int y = 0; y < 4; y++) begin
            pix[y * 8 + 1] = 8'd1;
            pix[y * 8 + 4] = 8'd2;
        end
        pix[3 * 8 + 2] = 8'd1;
        pix[3 * 8 + 3] = 8'd1;
        drive_frame(0);
        collect(100, dc, vc, to);
        e = exp_rec(1, 1, 4, 0, 3, 10, 25, 18, 1);
        checks++;
        if (to || dc !== 1 || got_q.size() !== 1) begin
            failures++;
            $display("[TB] FAIL u_count got=%0d done=%0d exp=1", got_q.size(), dc);
        end else begin
            checks++;
            if (got_q[0] !== e) begin
                failures++;
                $display("[TB] FAIL u_record got=%h exp=%h", got_q[0], e);
            end
        end
    endtask

    task automatic test_chain();
        int dc, vc; bit to; rec_t e;
        set_identity();
        ll_map[3] = 8'd2;
        ll_map[2] = 8'd1;
        blank_frame(8, 2);
        pix[0] = 8'd1; pix[2] = 8'd2; pix[3] = 8'd2;
        pix[5] = 8'd3; pix[6] = 8'd3; pix[7] = 8'd3; pix[8] = 8'd1;
        drive_frame(0);
        collect(100, dc, vc, to);
        e = exp_rec(1, 0, 7, 0, 1, 7, 23, 1, 1);
        checks++;
        if (to || dc !== 1 || got_q.size() !== 1) begin
            failures++;
            $display("[TB] FAIL chain_count got=%0d done=%0d exp=1", got_q.size(), dc);
        end else begin
            checks++;
            if (got_q[0] !== e) begin
                failures++;
                $display("[TB] FAIL chain_record got=%h exp=%h", got_q[0], e);
            end
        end
    endtask

    task automatic test_backpressure();
        int dc, vc; bit to, found, stable; rec_t first, e0, e1;
        set_identity();
        blank_frame(8, 2);
        pix[0] = 8'd1; pix[13] = 8'd4; pix[14] = 8'd4;
        e0 = exp_rec(1, 0, 0, 0, 0, 1, 0, 0, 0);
        e1 = exp_rec(4, 5, 6, 1, 1, 2, 11, 2, 1);
        drive_frame(0);
        blob_ready = 1'b0;
        wait_valid(found);
        first = cur_rec();
        checks++;
        if (!found || first !== e0) begin
            failures++;
            $display("[TB] FAIL bp_first found=%0b got=%h exp=%h", found, first, e0);
        end
        stable = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            if (!blob_valid || cur_rec() !== first) stable = 0;
        end
        checks++;
        if (!stable) begin
            failures++;
            $display("[TB] FAIL bp_hold got=%h exp=%h", cur_rec(), first);
        end
        collect(100, dc, vc, to);
        checks++;
        if (to || dc !== 1 || got_q.size() !== 2) begin
            failures++;
            $display("[TB] FAIL bp_count got=%0d done=%0d exp=2", got_q.size(), dc);
        end else begin
            checks++;
            if (got_q[0] !== e0 || got_q[1] !== e1) begin
                failures++;
                $display("[TB] FAIL bp_records got=%h,%h exp=%h,%h", got_q[0], got_q[1], e0, e1);
            end
        end
    endtask

    task automatic test_empty_frame();
        int dc, vc; bit to;
        set_identity();
        blank_frame(8, 4);
        drive_frame(0);
        collect(100, dc, vc, to);
        checks++;
        if (to || vc !== 0 || got_q.size() !== 0) begin
            failures++;
            $display("[TB] FAIL empty_records got=%0d valid_cycles=%0d exp=0", got_q.size(), vc);
        end
        checks++;
        if (dc !== 1) begin
            failures++;
            $display("[TB] FAIL empty_done got=%0d exp=1", dc);
        end
    endtask

    task automatic test_drop();
        int dc, vc; bit to, found; rec_t e0, e1, e2;
        set_identity();
        blank_frame(8, 3);
        pix[1] = 8'd3; pix[18] = 8'd6;
        e0 = exp_rec(3, 1, 1, 0, 0, 1, 1, 0, 0);
        e1 = exp_rec(6, 2, 2, 2, 2, 1, 2, 2, 1);
        drive_frame(0);
        blob_ready = 1'b0;
        wait_valid(found);
        checks++;
        if (!found || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL drop_busy found=%0b got=%b exp=1", found, busy);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            frame_valid = 1'b1; data_valid = 1'b1; label_in = 8'd9;
        end
        @(negedge clk);
        frame_valid = 1'b0; data_valid = 1'b0; label_in = '0;
        #1;
        checks++;
        if (frame_dropped !== 1'b1) begin
            failures++;
            $display("[TB] FAIL drop_flag got=%b exp=1", frame_dropped);
        end
        collect(100, dc, vc, to);
        checks++;
        if (to || dc !== 1 || got_q.size() !== 2) begin
            failures++;
            $display("[TB] FAIL drop_count got=%0d done=%0d exp=2", got_q.size(), dc);
        end else begin
            checks++;
            if (got_q[0] !== e0 || got_q[1] !== e1) begin
                failures++;
                $display("[TB] FAIL drop_records got=%h,%h exp=%h,%h", got_q[0], got_q[1], e0, e1);
            end
        end
        blank_frame(8, 1);
        pix[3] = 8'd7; pix[4] = 8'd7;
        e2 = exp_rec(7, 3, 4, 0, 0, 2, 7, 0, 1);
        drive_frame(0);
        collect(100, dc, vc, to);
        checks++;
        if (to || dc !== 1 || got_q.size() !== 1) begin
            failures++;
            $display("[TB] FAIL rearm_count got=%0d done=%0d exp=1", got_q.size(), dc);
        end else begin
            checks++;
            if (got_q[0] !== e2) begin
                failures++;
                $display("[TB] FAIL rearm_record got=%h exp=%h", got_q[0], e2);
            end
        end
        checks++;
        if (frame_dropped !== 1'b1) begin
            failures++;
            $display("[TB] FAIL drop_sticky got=%b exp=1", frame_dropped);
        end
    endtask

    task automatic test_random_frames();
        int dc, vc, r; bit to;
        for (int f = 0; f < 6; f++) begin
            fw = int'($urandom_range(4, 16));
            fh = int'($urandom_range(2, 8));
            pix.delete();
            for (int i = 0; i < fw * fh; i++) begin
                r = int'($urandom_range(0, 99));
                if (i > 0 && r < 30) pix.push_back(pix[i - 1]);
                else if (r < 55) pix.push_back(8'd0);
                else if (r < 60) pix.push_back(8'($urandom_range(250, 255)));
                else pix.push_back(8'($urandom_range(1, 24)));
            end
            ll_map[0] = 8'd0;
            for (int l = 1; l < 256; l++) begin
                case ($urandom_range(0, 3))
                    0: ll_map[l] = 8'(l);
                    1: ll_map[l] = 8'd0;
                    2: ll_map[l] = (l > 1) ? 8'($urandom_range(1, l - 1)) : 8'(l);
                    default: ll_map[l] = 8'($urandom_range(l, 255));
                endcase
            end
            model_frame();
            drive_frame((f % 2) ? 30 : 0);
            collect(60, dc, vc, to);
            checks++;
            if (to || dc !== 1) begin
                failures++;
                $display("[TB] FAIL rand_done frame=%0d got=%0d timeout=%0b exp=1", f, dc, to);
            end
            checks++;
            if (got_q.size() !== exp_q.size()) begin
                failures++;
                $display("[TB] FAIL rand_count frame=%0d got=%0d exp=%0d", f, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("[TB] FAIL rand_record frame=%0d idx=%0d got=%h exp=%h", f, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int dc, vc; bit to, found;
        set_identity();
        blank_frame(8, 1);
        pix[0] = 8'd2;
        drive_frame(0);
        blob_ready = 1'b0;
        wait_valid(found);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (!found || {blob_valid, blob_last, busy, frame_dropped} !== 4'b0) begin
            failures++;
            $display("[TB] FAIL midreset_outputs found=%0b got=%b exp=0000", found, {blob_valid, blob_last, busy, frame_dropped});
        end
        @(negedge clk);
        reset_n = 1'b1;
        drive_frame(0);
        collect(100, dc, vc, to);
        checks++;
        if (to || dc !== 1 || got_q.size() !== 1 || got_q[0] !== exp_rec(2, 0, 0, 0, 0, 1, 0, 0, 1)) begin
            failures++;
            $display("[TB] FAIL midreset_recover got=%0d done=%0d exp=1", got_q.size(), dc);
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_u_merge();
        test_chain();
        test_backpressure();
        test_empty_frame();
        test_drop();
        test_random_frames();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
